// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared widths, FSM encoding and stage-order constants for the stage sequencer
package seq_pkg;
    localparam int NA_DEF = 8;
    localparam int NC_DEF = 4;
    localparam int ND_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_BWD = 1'b1;
endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - loadable up/down counter that wraps between 0 and a runtime limit
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         adv,
    input  logic         down,
    input  logic [W-1:0] limit,
    output logic [W-1:0] out,
    output logic         at_limit
);
    // Counting down, the wrap point is 0 and the counter reloads to limit.
    assign at_limit = down ? (out == '0) : (out == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
        end else if (load) begin
            out <= load_val;
        end else if (adv) begin
            if (at_limit)
                out <= down ? limit : '0;
            else
                out <= down ? out - 1'b1 : out + 1'b1;
        end
    end
endmodule

// File: rtl/seq_stage_counter.sv
// rtl/seq_stage_counter.sv - step/stage/epoch run sequencer with runtime step table
module seq_stage_counter
    import seq_pkg::*;
#(
    parameter int NA   = NA_DEF,
    parameter int NC   = NC_DEF,
    parameter int NSTG = 2**NC,
    parameter int ND   = ND_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          en,
    input  logic          mode,
    input  logic [NC-1:0] num_stage,
    input  logic [ND-1:0] stop_epoch,
    input  logic          cfg_we,
    input  logic [NC-1:0] cfg_addr,
    input  logic [NA-1:0] cfg_data,
    output logic [NA-1:0] count_step,
    output logic [NC-1:0] count_stage,
    output logic [ND-1:0] count_epoch,
    output logic          last_step,
    output logic          last_stage,
    output logic          last_epoch,
    output logic          busy,
    output logic          done
);
    state_t        state_q, state_d;
    logic          mode_r;
    logic [NC-1:0] num_stage_r;
    logic [ND-1:0] stop_epoch_r;
    logic [NA-1:0] step_table [NSTG];

    logic          go, advance, load;
    logic          step_at, stage_at, epoch_at;
    logic [NC-1:0] stage_start;

    assign go      = (state_q == IDLE) && start && !abort;
    assign advance = (state_q == RUN) && en && !abort;
    assign load    = abort || go;

    // Abort loads zeros; a start loads the mode-dependent first stage.
    assign stage_start = (!abort && mode == MODE_BWD) ? num_stage : '0;

    assign busy       = (state_q == RUN);
    assign last_step  = busy && step_at;
    assign last_stage = last_step && stage_at;
    assign last_epoch = last_stage && epoch_at;

    wrap_counter #(.W(NA)) u_step (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val ('0),
        .adv      (advance),
        .down     (1'b0),
        .limit    (step_table[count_stage]),
        .out      (count_step),
        .at_limit (step_at)
    );

    wrap_counter #(.W(NC)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (stage_start),
        .adv      (advance && step_at),
        .down     (mode_r),
        .limit    (num_stage_r),
        .out      (count_stage),
        .at_limit (stage_at)
    );

    wrap_counter #(.W(ND)) u_epoch (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val ('0),
        .adv      (advance && step_at && stage_at),
        .down     (1'b0),
        .limit    (stop_epoch_r),
        .out      (count_epoch),
        .at_limit (epoch_at)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= advance && last_epoch;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (en && last_epoch) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_r       <= MODE_FWD;
            num_stage_r  <= '0;
            stop_epoch_r <= '0;
        end else if (go) begin
            mode_r       <= mode;
            num_stage_r  <= num_stage;
            stop_epoch_r <= stop_epoch;
        end
    end

    // The table is frozen during a run, so the step limit cannot change mid-run.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSTG; i++)
                step_table[i] <= '0;
        end else if (state_q == IDLE && cfg_we) begin
            step_table[cfg_addr] <= cfg_data;
        end
    end
endmodule
